dmem_arbiter: RTL and testbench

- Serialises data-memory traffic from the two cores onto one single-port, synchronous-read data memory.
- Sits between the two cpu instances' data-memory ports and a single-port dmem.
- Gives each core a req/ack handshake and arbitrates round-robin.
- Stalling a core until its ack arrives is the core's responsibility.

---
 rtl/dmem_arbiter_if.sv | 44 ++++
 rtl/dmem_arbiter.sv | 94 +++++++++
 tb/tb_dmem_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two core data ports and the single-port memory port seen by dmem_arbiter.
// slave is the arbiter's view; master is the cores' and memory's view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              c0_req;
  logic              c0_we;
  logic [ADDR_W-1:0] c0_addr;
  logic [DATA_W-1:0] c0_wdata;
  logic [DATA_W-1:0] c0_rdata;
  logic              c0_ack;

  logic              c1_req;
  logic              c1_we;
  logic [ADDR_W-1:0] c1_addr;
  logic [DATA_W-1:0] c1_wdata;
  logic [DATA_W-1:0] c1_rdata;
  logic              c1_ack;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  c0_req, c0_we, c0_addr, c0_wdata,
    output c0_rdata, c0_ack,
    input  c1_req, c1_we, c1_addr, c1_wdata,
    output c1_rdata, c1_ack,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output c0_req, c0_we, c0_addr, c0_wdata,
    input  c0_rdata, c0_ack,
    output c1_req, c1_we, c1_addr, c1_wdata,
    input  c1_rdata, c1_ack,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter serialising two cores' data accesses onto one synchronous-read memory.
//   state   | meaning
//   S_IDLE  | sample requests, latch the winner's access
//   S_ISSUE | strobe m_en with the latched access
//   S_WAIT  | memory read data arrives; load the winner's rdata on reads
//   S_DONE  | one-cycle ack to the winner; requests ignored
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk_i,
  input  logic           reset_ni,
  dmem_arbiter_if.slave  bus,
  output logic           last_grant_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      last_q  <= 1'b1;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.c0_req || bus.c1_req) begin
          // a lone requester wins outright; a tie goes to the core that did not win last
          gnt_d   = (bus.c0_req && bus.c1_req) ? ~last_q : bus.c1_req;
          we_d    = gnt_d ? bus.c1_we    : bus.c0_we;
          addr_d  = gnt_d ? bus.c1_addr  : bus.c0_addr;
          wdata_d = gnt_d ? bus.c1_wdata : bus.c0_wdata;
          last_d  = gnt_d;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (!we_q) begin
          if (gnt_q) rd1_d = bus.m_rdata;
          else       rd0_d = bus.m_rdata;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.m_en     = (state_q == S_ISSUE);
  assign bus.m_we     = (state_q == S_ISSUE) && we_q;
  assign bus.m_addr   = addr_q;
  assign bus.m_wdata  = wdata_q;
  assign bus.c0_ack   = (state_q == S_DONE) && !gnt_q;
  assign bus.c1_ack   = (state_q == S_DONE) &&  gnt_q;
  assign bus.c0_rdata = rd0_q;
  assign bus.c1_rdata = rd1_q;
  assign last_grant_o = last_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction vector table plus reset, contention and req-drop sequences.
module tb_dmem_arbiter;

  logic clk_i = 1'b0;
  logic reset_ni;
  logic last_grant_o;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .bus         (bus),
    .last_grant_o(last_grant_o)
  );

  always #5 clk_i = ~clk_i;

  // synchronous-read memory model, word indexed
  logic [31:0] mem [0:255];
  always @(posedge clk_i) begin
    if (bus.m_en) begin
      if (bus.m_we) mem[bus.m_addr[9:2]] <= bus.m_wdata;
      else          bus.m_rdata <= mem[bus.m_addr[9:2]];
    end
  end

  typedef struct {
    logic        r0;
    logic        w0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        r1;
    logic        w1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic        g;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [8];
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rd0 = 32'h0;
  logic [31:0] exp_rd1 = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic        ewe;
    logic [31:0] eaddr, ewd;
    int          acks, m_ens;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    bus.m_rdata = 32'h0;
    bus.c0_req = 1'b0; bus.c0_we = 1'b0; bus.c0_addr = 32'h0; bus.c0_wdata = 32'h0;
    bus.c1_req = 1'b0; bus.c1_we = 1'b0; bus.c1_addr = 32'h0; bus.c1_wdata = 32'h0;

    //            r0    w0    a0        d0            r1    w1    a1        d1        g     rd
    vecs[0] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h30, 32'h1234, 1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h20, 32'h0,        1'b1, 1'b1, 32'h20, 32'h55,   1'b0, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b1, 32'h20, 32'h55,   1'b1, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h30, 32'h0,    1'b1, 32'h1234};
    vecs[6] = '{1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 32'h55};
    vecs[7] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 1'b0, 32'h10, 32'h0,    1'b1, 32'hDEADBEEF};

    // reset held for three cycles
    reset_ni = 1'b0;
    repeat (3) tick();
    check("rst m_en",     {31'h0, bus.m_en},   32'h0);
    check("rst m_we",     {31'h0, bus.m_we},   32'h0);
    check("rst m_addr",   bus.m_addr,          32'h0);
    check("rst m_wdata",  bus.m_wdata,         32'h0);
    check("rst c0_ack",   {31'h0, bus.c0_ack}, 32'h0);
    check("rst c1_ack",   {31'h0, bus.c1_ack}, 32'h0);
    check("rst c0_rdata", bus.c0_rdata,        32'h0);
    check("rst c1_rdata", bus.c1_rdata,        32'h0);
    check("rst last_grant", {31'h0, last_grant_o}, 32'h1);
    reset_ni = 1'b1;
    m_ens = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.m_en) m_ens++;
    end
    check("idle m_en count", m_ens, 0);

    // table-driven single transactions
    for (int i = 0; i < 8; i++) begin
      bus.c0_req = vecs[i].r0; bus.c0_we = vecs[i].w0; bus.c0_addr = vecs[i].a0; bus.c0_wdata = vecs[i].d0;
      bus.c1_req = vecs[i].r1; bus.c1_we = vecs[i].w1; bus.c1_addr = vecs[i].a1; bus.c1_wdata = vecs[i].d1;
      ewe   = vecs[i].g ? vecs[i].w1 : vecs[i].w0;
      eaddr = vecs[i].g ? vecs[i].a1 : vecs[i].a0;
      ewd   = vecs[i].g ? vecs[i].d1 : vecs[i].d0;
      tick();
      check($sformatf("v%0d m_en", i), {31'h0, bus.m_en}, 32'h1);
      check($sformatf("v%0d m_we", i), {31'h0, bus.m_we}, {31'h0, ewe});
      check($sformatf("v%0d m_addr", i), bus.m_addr, eaddr);
      if (ewe) check($sformatf("v%0d m_wdata", i), bus.m_wdata, ewd);
      check($sformatf("v%0d last_grant", i), {31'h0, last_grant_o}, {31'h0, vecs[i].g});
      tick();
      check($sformatf("v%0d wait m_en", i), {31'h0, bus.m_en}, 32'h0);
      tick();
      if (!ewe) begin
        if (vecs[i].g) exp_rd1 = vecs[i].rd;
        else           exp_rd0 = vecs[i].rd;
      end
      check($sformatf("v%0d c0_ack", i), {31'h0, bus.c0_ack}, {31'h0, ~vecs[i].g});
      check($sformatf("v%0d c1_ack", i), {31'h0, bus.c1_ack}, {31'h0, vecs[i].g});
      check($sformatf("v%0d c0_rdata", i), bus.c0_rdata, exp_rd0);
      check($sformatf("v%0d c1_rdata", i), bus.c1_rdata, exp_rd1);
      if (vecs[i].g) bus.c1_req = 1'b0;
      else           bus.c0_req = 1'b0;
      tick();
      check($sformatf("v%0d idle acks", i), {30'h0, bus.c1_ack, bus.c0_ack}, 32'h0);
    end

    // sustained contention: eight transactions, grants alternate starting with core0
    bus.c0_req = 1'b1; bus.c0_we = 1'b0; bus.c0_addr = 32'h10;
    bus.c1_req = 1'b1; bus.c1_we = 1'b0; bus.c1_addr = 32'h30;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (i % 4 == 0) check($sformatf("cont%0d last_grant", i / 4), {31'h0, last_grant_o}, (i / 4) % 2);
      check($sformatf("cont c0_ack@%0d", i), {31'h0, bus.c0_ack},
            (i % 4 == 2 && (i / 4) % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("cont c1_ack@%0d", i), {31'h0, bus.c1_ack},
            (i % 4 == 2 && (i / 4) % 2 == 1) ? 32'h1 : 32'h0);
      if (i == 31) begin
        bus.c0_req = 1'b0;
        bus.c1_req = 1'b0;
      end
    end
    check("cont c0_rdata", bus.c0_rdata, 32'hDEADBEEF);
    check("cont c1_rdata", bus.c1_rdata, 32'h1234);
    tick();
    check("cont quiet m_en", {31'h0, bus.m_en}, 32'h0);

    // reset during the WAIT cycle of a core1 read
    bus.c1_req = 1'b1; bus.c1_we = 1'b0; bus.c1_addr = 32'h30;
    tick();
    check("rw issue m_en", {31'h0, bus.m_en}, 32'h1);
    tick();
    reset_ni = 1'b0;
    tick();
    check("rw c1_ack", {31'h0, bus.c1_ack}, 32'h0);
    check("rw c1_rdata", bus.c1_rdata, 32'h0);
    check("rw c0_rdata", bus.c0_rdata, 32'h0);
    check("rw m_en", {31'h0, bus.m_en}, 32'h0);
    check("rw last_grant", {31'h0, last_grant_o}, 32'h1);
    tick();
    check("rw held c1_ack", {31'h0, bus.c1_ack}, 32'h0);
    reset_ni = 1'b1;
    tick();
    check("rw retry m_en", {31'h0, bus.m_en}, 32'h1);
    check("rw retry m_addr", bus.m_addr, 32'h30);
    tick();
    tick();
    check("rw retry c1_ack", {31'h0, bus.c1_ack}, 32'h1);
    check("rw retry c1_rdata", bus.c1_rdata, 32'h1234);
    bus.c1_req = 1'b0;
    tick();

    // core0 drops req during ISSUE and changes its address
    bus.c0_req = 1'b1; bus.c0_we = 1'b0; bus.c0_addr = 32'h10;
    tick();
    check("drop m_addr", bus.m_addr, 32'h10);
    bus.c0_req = 1'b0; bus.c0_addr = 32'h40;
    acks = 0;
    m_ens = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.c0_ack) acks++;
      if (bus.m_en) m_ens++;
      if (i == 0) check("drop wait m_addr", bus.m_addr, 32'h10);
      if (i == 1) begin
        check("drop c0_ack", {31'h0, bus.c0_ack}, 32'h1);
        check("drop c0_rdata", bus.c0_rdata, 32'hDEADBEEF);
      end
    end
    check("drop ack count", acks, 1);
    check("drop m_en count", m_ens, 0);
    check("drop c1_ack", {31'h0, bus.c1_ack}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
